// File: rtl/depp_txfifo.sv
// Transmit byte FIFO for the DEPP byte port: bus-side writes are queued in a
// small memory and presented one at a time through a registered output stage.
module depp_txfifo #(
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_stb,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_clr_ovfl,
    output logic              o_tx_stb,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN + 1)'(DEPTH);

    // Handshake: o_tx_stb is valid, i_tx_busy low is ready; the byte in
    // o_tx_data transfers on any rising edge where both hold.
    logic [7:0]        mem_q [DEPTH];
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   cnt_q, cnt_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovfl_q, ovfl_d;
    logic              tx_stb_q, tx_stb_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              push, accept, load;

    always_comb begin
        push     = i_wr_stb && !full_q;
        accept   = tx_stb_q && !i_tx_busy;
        load     = (cnt_q != '0) && (!tx_stb_q || accept);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (load) rd_ptr_d = rd_ptr_q + 1'b1;

        cnt_d = cnt_q;
        case ({push, load})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Output register is frozen unless a new byte is loaded or the current one leaves.
        tx_stb_d  = load || (tx_stb_q && !accept);
        tx_data_d = load ? mem_q[rd_ptr_q] : tx_data_q;

        // Status flags are derived from next-state values so they match the data path exactly.
        fill_d  = cnt_d + {{LGFLEN{1'b0}}, tx_stb_d};
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0) && !tx_stb_d;

        ovfl_d = ovfl_q;
        if (i_wr_stb && full_q) ovfl_d = 1'b1;
        else if (i_clr_ovfl)    ovfl_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) mem_q[wr_ptr_q] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovfl_q    <= 1'b0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovfl_q    <= ovfl_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_fill     = fill_q;
    assign o_overflow = ovfl_q;
    assign o_tx_stb   = tx_stb_q;
    assign o_tx_data  = tx_data_q;

endmodule
